// File: rtl/instr_fetch_pkg.sv
// Shared widths, reset address and FSM state encoding for the instruction fetch unit.
package instr_fetch_pkg;

  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned INSTR_W = 28;

  localparam logic [ADDR_W-1:0] RESET_ADDR = 11'h400;

  typedef logic [1:0] ifetch_state_t;

  localparam ifetch_state_t S_IDLE = 2'd0;
  localparam ifetch_state_t S_REQ  = 2'd1;
  localparam ifetch_state_t S_PEND = 2'd2;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: PC/control inputs, instruction-memory port and decode handshake.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W  = instr_fetch_pkg::ADDR_W,
  parameter int unsigned INSTR_W = instr_fetch_pkg::INSTR_W
);

  logic [ADDR_W-1:0]  pcresult;
  logic               fetch_start;
  logic               flush;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] ir;
  logic               ir_valid;
  logic               ir_ready;
  logic               busy;
  logic               fetch_done;
  logic               fetch_err;

  modport master (
    input  pcresult, fetch_start, flush, mem_ack, mem_rdata, ir_ready,
    output mem_req, mem_addr, ir, ir_valid, busy, fetch_done, fetch_err
  );

  modport slave (
    output pcresult, fetch_start, flush, mem_ack, mem_rdata, ir_ready,
    input  mem_req, mem_addr, ir, ir_valid, busy, fetch_done, fetch_err
  );

endinterface

// File: rtl/fetch_timer.sv
// Request timeout counter; only instantiated when IFETCH_TIMEOUT_EN is defined.
module fetch_timer #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 8'd0;
    end else if (i_clear) begin
      r_cnt <= 8'd0;
    end else if (i_run) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Fires during the TIMEOUT_CYC-th request cycle, so mem_req is high exactly that long.
  assign o_expired = i_run && (r_cnt == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM (IDLE/REQ/PEND) with a one-entry skid buffer.
// Optional request timeout enabled by defining IFETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter int unsigned ADDR_W      = instr_fetch_pkg::ADDR_W,
  parameter int unsigned INSTR_W     = instr_fetch_pkg::INSTR_W,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);
  import instr_fetch_pkg::*;

  ifetch_state_t      r_state, w_state_nxt;
  logic               r_mem_req, w_req_nxt;
  logic [ADDR_W-1:0]  r_mem_addr, w_addr_nxt;
  logic [INSTR_W-1:0] r_ir, w_ir_nxt;
  logic               r_ir_valid, w_valid_nxt;
  logic [INSTR_W-1:0] r_skid, w_skid_nxt;
  logic               r_fetch_done, w_done_nxt;
  logic               r_drop, w_drop_nxt;
  logic               w_ir_free, w_start, w_timeout;

  assign w_ir_free = !r_ir_valid || bus.ir_ready;
  assign w_start   = (r_state == S_IDLE) && bus.fetch_start && !bus.flush;

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_mem_req;
    w_addr_nxt  = r_mem_addr;
    w_ir_nxt    = r_ir;
    w_valid_nxt = r_ir_valid;
    w_skid_nxt  = r_skid;
    w_done_nxt  = 1'b0;
    w_drop_nxt  = r_drop;
    if (r_ir_valid && bus.ir_ready) w_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_REQ;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = bus.pcresult;
          w_drop_nxt  = 1'b0;
        end else if (bus.flush) begin
          w_valid_nxt = 1'b0;
        end
      end
      S_REQ: begin
        // A flushed request stays on the bus until acked; r_drop discards its data.
        if (bus.flush) begin
          w_valid_nxt = 1'b0;
          w_drop_nxt  = 1'b1;
        end
        if (bus.mem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
          w_drop_nxt  = 1'b0;
          if (!(r_drop || bus.flush)) begin
            if (w_ir_free) begin
              w_ir_nxt    = bus.mem_rdata;
              w_valid_nxt = 1'b1;
              w_done_nxt  = 1'b1;
            end else begin
              w_skid_nxt  = bus.mem_rdata;
              w_state_nxt = S_PEND;
            end
          end
        end else if (w_timeout) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
          w_drop_nxt  = 1'b0;
        end
      end
      S_PEND: begin
        if (bus.flush) begin
          w_valid_nxt = 1'b0;
          w_skid_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else if (w_ir_free) begin
          w_ir_nxt    = r_skid;
          w_valid_nxt = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= RESET_ADDR;
      r_ir         <= '0;
      r_ir_valid   <= 1'b0;
      r_skid       <= '0;
      r_fetch_done <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_req    <= w_req_nxt;
      r_mem_addr   <= w_addr_nxt;
      r_ir         <= w_ir_nxt;
      r_ir_valid   <= w_valid_nxt;
      r_skid       <= w_skid_nxt;
      r_fetch_done <= w_done_nxt;
      r_drop       <= w_drop_nxt;
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  logic r_fetch_err;

  fetch_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_start),
    .i_run     ((r_state == S_REQ) && !bus.mem_ack),
    .o_expired (w_timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_err <= 1'b0;
    end else if (w_start) begin
      r_fetch_err <= 1'b0;
    end else if (w_timeout) begin
      r_fetch_err <= 1'b1;
    end
  end

  assign bus.fetch_err = r_fetch_err;
`else
  assign w_timeout     = 1'b0;
  assign bus.fetch_err = 1'b0;
`endif

  assign bus.mem_req    = r_mem_req;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.ir         = r_ir;
  assign bus.ir_valid   = r_ir_valid;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.fetch_done = r_fetch_done;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch; timeout checks follow IFETCH_TIMEOUT_EN.
module tb_instr_fetch;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  instr_fetch_if u_if ();

  instr_fetch #(
    .TIMEOUT_CYC (15)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fs;
    logic        fl;
    logic [10:0] pc;
    logic        ack;
    logic [27:0] rd;
    logic        rdy;
    logic        e_req;
    logic [10:0] e_addr;
    logic [27:0] e_ir;
    logic        e_v;
    logic        e_done;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];
  int   n_pass   = 0;
  int   n_checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input logic fs, input logic fl, input logic [10:0] pc, input logic ack,
                     input logic [27:0] rd, input logic rdy, input logic e_req,
                     input logic [10:0] e_addr, input logic [27:0] e_ir, input logic e_v,
                     input logic e_done, input logic e_busy);
    vec_t v;
    v.fs = fs; v.fl = fl; v.pc = pc; v.ack = ack; v.rd = rd; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ir = e_ir; v.e_v = e_v;
    v.e_done = e_done; v.e_busy = e_busy;
    vq.push_back(v);
  endtask

  task automatic drive(input logic fs, input logic fl, input logic [10:0] pc, input logic ack,
                       input logic [27:0] rd, input logic rdy);
    @(negedge clk);
    u_if.fetch_start = fs;
    u_if.flush       = fl;
    u_if.pcresult    = pc;
    u_if.mem_ack     = ack;
    u_if.mem_rdata   = rd;
    u_if.ir_ready    = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_req, input logic [10:0] e_addr,
                            input logic [27:0] e_ir, input logic e_v, input logic e_done,
                            input logic e_busy);
    chk({tag, ".mem_req"},    32'(u_if.mem_req),    32'(e_req));
    chk({tag, ".mem_addr"},   32'(u_if.mem_addr),   32'(e_addr));
    chk({tag, ".ir"},         32'(u_if.ir),         32'(e_ir));
    chk({tag, ".ir_valid"},   32'(u_if.ir_valid),   32'(e_v));
    chk({tag, ".fetch_done"}, 32'(u_if.fetch_done), 32'(e_done));
    chk({tag, ".busy"},       32'(u_if.busy),       32'(e_busy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    u_if.fetch_start = 1'b0;
    u_if.flush       = 1'b0;
    u_if.pcresult    = 11'h000;
    u_if.mem_ack     = 1'b0;
    u_if.mem_rdata   = 28'h0;
    u_if.ir_ready    = 1'b1;

    #12;
    check_outs("reset", 1'b0, 11'h400, 28'h0, 1'b0, 1'b0, 1'b0);
    chk("reset.fetch_err", 32'(u_if.fetch_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // fs fl pc ack rdata rdy | req addr ir valid done busy
    add(1, 0, 11'h400, 0, 28'h0,       1, 1, 11'h400, 28'h0,       0, 0, 1);
    add(0, 0, 11'h400, 0, 28'h0,       1, 1, 11'h400, 28'h0,       0, 0, 1);
    add(0, 0, 11'h400, 1, 28'h0ABCDEF, 1, 0, 11'h400, 28'h0ABCDEF, 1, 1, 0);
    add(0, 0, 11'h400, 0, 28'h0,       1, 0, 11'h400, 28'h0ABCDEF, 0, 0, 0);
    add(1, 0, 11'h123, 0, 28'h0,       0, 1, 11'h123, 28'h0ABCDEF, 0, 0, 1);
    add(0, 0, 11'h123, 1, 28'h1111111, 0, 0, 11'h123, 28'h1111111, 1, 1, 0);
    add(1, 0, 11'h124, 0, 28'h0,       0, 1, 11'h124, 28'h1111111, 1, 0, 1);
    add(0, 0, 11'h124, 1, 28'h1234567, 0, 0, 11'h124, 28'h1111111, 1, 0, 1);
    add(0, 0, 11'h124, 0, 28'h0,       0, 0, 11'h124, 28'h1111111, 1, 0, 1);
    add(0, 0, 11'h124, 0, 28'h0,       1, 0, 11'h124, 28'h1234567, 1, 1, 0);
    add(0, 0, 11'h124, 0, 28'h0,       1, 0, 11'h124, 28'h1234567, 0, 0, 0);
    add(1, 0, 11'h200, 0, 28'h0,       1, 1, 11'h200, 28'h1234567, 0, 0, 1);
    add(1, 0, 11'h300, 0, 28'h0,       1, 1, 11'h200, 28'h1234567, 0, 0, 1);
    add(0, 0, 11'h300, 1, 28'h0000042, 1, 0, 11'h200, 28'h0000042, 1, 1, 0);
    add(1, 0, 11'h250, 0, 28'h0,       0, 1, 11'h250, 28'h0000042, 1, 0, 1);
    add(0, 1, 11'h250, 0, 28'h0,       0, 1, 11'h250, 28'h0000042, 0, 0, 1);
    add(0, 0, 11'h250, 1, 28'hFFFFFFF, 0, 0, 11'h250, 28'h0000042, 0, 0, 0);
    add(0, 0, 11'h250, 1, 28'h5555555, 1, 0, 11'h250, 28'h0000042, 0, 0, 0);
    add(1, 1, 11'h111, 0, 28'h0,       1, 0, 11'h250, 28'h0000042, 0, 0, 0);
    add(1, 0, 11'h0AA, 0, 28'h0,       1, 1, 11'h0AA, 28'h0000042, 0, 0, 1);
    add(0, 0, 11'h0AA, 1, 28'h0000A0A, 1, 0, 11'h0AA, 28'h0000A0A, 1, 1, 0);
    add(1, 0, 11'h0AB, 0, 28'h0,       0, 1, 11'h0AB, 28'h0000A0A, 1, 0, 1);
    add(0, 0, 11'h0AB, 1, 28'h0000B0B, 0, 0, 11'h0AB, 28'h0000A0A, 1, 0, 1);
    add(0, 1, 11'h0AB, 0, 28'h0,       0, 0, 11'h0AB, 28'h0000A0A, 0, 0, 0);
    add(0, 0, 11'h0AB, 0, 28'h0,       1, 0, 11'h0AB, 28'h0000A0A, 0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].fs, vq[i].fl, vq[i].pc, vq[i].ack, vq[i].rd, vq[i].rdy);
      step();
      check_outs($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_ir,
                 vq[i].e_v, vq[i].e_done, vq[i].e_busy);
    end

`ifdef IFETCH_TIMEOUT_EN
    drive(1, 0, 11'h055, 0, 28'h0, 1);
    step();
    cnt = 0;
    for (int k = 0; k < 40 && u_if.mem_req; k++) begin
      cnt++;
      drive(0, 0, 11'h055, 0, 28'h0, 1);
      step();
    end
    chk("tmo.req_cycles", 32'(cnt), 32'd15);
    chk("tmo.fetch_err", 32'(u_if.fetch_err), 32'd1);
    chk("tmo.busy", 32'(u_if.busy), 32'd0);
    chk("tmo.fetch_done", 32'(u_if.fetch_done), 32'd0);
    drive(1, 0, 11'h056, 0, 28'h0, 1);
    step();
    chk("tmo.err_cleared", 32'(u_if.fetch_err), 32'd0);
    chk("tmo.req_again", 32'(u_if.mem_req), 32'd1);
    drive(0, 0, 11'h056, 1, 28'h0000777, 1);
    step();
    chk("tmo.ir", 32'(u_if.ir), 32'h0000777);
    chk("tmo.done", 32'(u_if.fetch_done), 32'd1);
`else
    drive(1, 0, 11'h055, 0, 28'h0, 1);
    step();
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 11'h055, 0, 28'h0, 1);
      step();
    end
    chk("wait.req_held", 32'(u_if.mem_req), 32'd1);
    chk("wait.busy", 32'(u_if.busy), 32'd1);
    chk("wait.fetch_err", 32'(u_if.fetch_err), 32'd0);
    drive(0, 0, 11'h055, 1, 28'h0000777, 1);
    step();
    chk("wait.ir", 32'(u_if.ir), 32'h0000777);
    chk("wait.done", 32'(u_if.fetch_done), 32'd1);
`endif

    // Asynchronous reset while a request is outstanding.
    drive(1, 0, 11'h333, 0, 28'h0, 0);
    step();
    chk("rstreq.req_before", 32'(u_if.mem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_outs("rstreq", 1'b0, 11'h400, 28'h0, 1'b0, 1'b0, 1'b0);
    chk("rstreq.fetch_err", 32'(u_if.fetch_err), 32'd0);
    drive(0, 0, 11'h333, 1, 28'h0999999, 1);
    step();
    @(negedge clk);
    reset = 1'b1;
    step();
    check_outs("lateack", 1'b0, 11'h400, 28'h0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
